axi_lite_rw_arbiter: RTL and testbench

AXI_LITE_RW_ARBITER -- requirements
Module: axi_lite_rw_arbiter

---
 rtl/axi_lite_rw_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_lite_rw_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rw_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_rw_arbiter
//
// Purpose: AXI-Lite slave front end that holds one AW, one W and one AR beat,
// arbitrates between a complete write (AW+W) and a read, and turns the granted
// access into a single-transfer request to a bridge core. The core's response
// (or a timeout) is returned on the AXI B or R channel.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   axi_aw*/axi_w*/axi_ar* AXI-Lite request channels (slave side)
//   axi_b*/axi_r*          AXI-Lite response channels (slave side)
//   req_valid/req_ready    request handshake to the core
//   req_write/req_addr/req_wdata  request payload, stable while req_valid
//   rsp_valid/rsp_rdata/rsp_err   completion pulse from the core
//   busy                   high whenever the FSM is not in IDLE
//
// Handshake semantics: every valid/ready pair transfers exactly when both are
// high at a rising edge of aclk. A source holds valid and its payload stable
// until that edge; ready may be driven independently of valid.
// ---------------------------------------------------------------------------
module axi_lite_rw_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [DATA_W-1:0] axi_wdata,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  output logic [1:0]        axi_bresp,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  output logic [DATA_W-1:0] axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_err,
  output logic              busy
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_WRESP    = 3'd3,
    S_RRESP    = 3'd4
  } state_e;

  // One-entry channel holding registers
  logic              aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0] w_data_q;

  // FSM and response registers
  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              req_write_q, req_write_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  logic              wr_pend, rd_pend, grant_wr, grant_rd;
  logic [ADDR_W-1:0] grant_addr;
  logic              wr_done, rd_done;

  assign wr_pend = aw_full_q & w_full_q;
  assign rd_pend = ar_full_q;
  // On a tie the type that did not win last time goes first.
  assign grant_wr   = wr_pend & (~rd_pend | ~last_wr_q);
  assign grant_rd   = rd_pend & ~grant_wr;
  assign grant_addr = grant_wr ? aw_addr_q : ar_addr_q;

  assign wr_done = (state_q == S_WRESP) & axi_bready;
  assign rd_done = (state_q == S_RRESP) & axi_rready;

  // Ready is forced low while reset is asserted so nothing is accepted then.
  assign axi_awready = aresetn & ~aw_full_q;
  assign axi_wready  = aresetn & ~w_full_q;
  assign axi_arready = aresetn & ~ar_full_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      ar_addr_q <= '0;
    end else begin
      // A register only fills while empty and only drains in its response
      // state, where it is full, so set and clear never coincide.
      if (axi_awvalid && !aw_full_q) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= axi_awaddr;
      end else if (wr_done) begin
        aw_full_q <= 1'b0;
      end
      if (axi_wvalid && !w_full_q) begin
        w_full_q <= 1'b1;
        w_data_q <= axi_wdata;
      end else if (wr_done) begin
        w_full_q <= 1'b0;
      end
      if (axi_arvalid && !ar_full_q) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= axi_araddr;
      end else if (rd_done) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      last_wr_q   <= 1'b0;
      cnt_q       <= '0;
      resp_q      <= RESP_OKAY;
      rdata_q     <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    rdata_d     = rdata_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_valid   = 1'b0;
    axi_bvalid  = 1'b0;
    axi_rvalid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_wr || grant_rd) begin
          last_wr_d = grant_wr;
          if (grant_addr[1:0] != 2'b00) begin
            // Unaligned access never reaches the core.
            state_d = grant_wr ? S_WRESP : S_RRESP;
            resp_d  = RESP_SLVERR;
            rdata_d = '0;
          end else begin
            state_d     = S_ISSUE;
            req_write_d = grant_wr;
            req_addr_d  = grant_addr;
            req_wdata_d = grant_wr ? w_data_q : '0;
          end
        end
      end

      S_ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) begin
          state_d = S_WAIT_RSP;
          cnt_d   = '0;
        end
      end

      S_WAIT_RSP: begin
        // A completion in the final counted cycle takes priority over timeout.
        if (rsp_valid) begin
          state_d = req_write_q ? S_WRESP : S_RRESP;
          resp_d  = rsp_err ? RESP_SLVERR : RESP_OKAY;
          rdata_d = req_write_q ? '0 : rsp_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = req_write_q ? S_WRESP : S_RRESP;
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WRESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) state_d = S_IDLE;
      end

      S_RRESP: begin
        axi_rvalid = 1'b1;
        if (axi_rready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign axi_bresp = resp_q;
  assign axi_rresp = resp_q;
  assign axi_rdata = rdata_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_lite_rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_rw_arbiter
//
// Directed bench for axi_lite_rw_arbiter. Stimulus tasks push the expected
// core requests, B responses and R responses into queues; a monitor pops and
// compares whenever the DUT completes a handshake. A small core model answers
// requests after a programmable delay.
// ---------------------------------------------------------------------------
module tb_axi_lite_rw_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          aclk, aresetn;
  logic [AW-1:0] axi_awaddr, axi_araddr, req_addr;
  logic [DW-1:0] axi_wdata, axi_rdata, req_wdata, rsp_rdata;
  logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [1:0]    axi_bresp, axi_rresp;
  logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic          axi_rvalid, axi_rready;
  logic          req_valid, req_ready, req_write, rsp_valid, rsp_err, busy;

  axi_lite_rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [AW+DW:0] exp_req_q[$];
  logic [1:0]     exp_b_q[$];
  logic [DW+1:0]  exp_r_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int hs_cyc   = 0;
  int rsp_cyc  = 0;

  // core model controls
  logic          core_en  = 1'b1;
  int            core_dly = 2;
  logic [DW-1:0] core_rdata = '0;
  logic          core_err = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge aclk) begin
    if (aresetn) begin
      if (req_valid && req_ready) begin
        hs_cyc = cyc;
        if (exp_req_q.size() == 0) flag("req_unexpected");
        else check("req_payload", {req_write, req_addr, req_wdata}, exp_req_q.pop_front());
      end
      if (axi_bvalid && axi_bready) begin
        if (exp_b_q.size() == 0) flag("b_unexpected");
        else check("bresp", axi_bresp, exp_b_q.pop_front());
      end
      if (axi_rvalid && axi_rready) begin
        if (exp_r_q.size() == 0) flag("r_unexpected");
        else check("rdata_rresp", {axi_rdata, axi_rresp}, exp_r_q.pop_front());
      end
      if (axi_bvalid || axi_rvalid) check("b_r_exclusive", axi_bvalid & axi_rvalid, 1'b0);
    end
  end

  // ---------------- core model ----------------
  initial begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && req_valid && req_ready && core_en) begin
        repeat (core_dly) @(posedge aclk);
        #1;
        rsp_valid = 1'b1;
        rsp_rdata = core_rdata;
        rsp_err   = core_err;
        rsp_cyc   = cyc;
        @(posedge aclk);
        #1;
        rsp_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge aclk); #1;
    axi_awvalid = 1'b1; axi_awaddr = a; axi_wvalid = 1'b1; axi_wdata = d;
    @(posedge aclk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
  endtask

  task automatic send_read(input logic [AW-1:0] a);
    @(posedge aclk); #1;
    axi_arvalid = 1'b1; axi_araddr = a;
    @(posedge aclk); #1;
    axi_arvalid = 1'b0;
  endtask

  task automatic send_both(input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input logic [AW-1:0] ra);
    @(posedge aclk); #1;
    axi_awvalid = 1'b1; axi_awaddr = wa; axi_wvalid = 1'b1; axi_wdata = wd;
    axi_arvalid = 1'b1; axi_araddr = ra;
    @(posedge aclk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // which: 0 = req_valid, 1 = bvalid, 2 = rvalid
  task automatic wait_for(input int which, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge aclk);
      case (which)
        0: hit = req_valid;
        1: hit = axi_bvalid;
        default: hit = axi_rvalid;
      endcase
    end
    if (!hit) flag({"timeout_", name});
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge aclk);
      done = !busy && exp_req_q.size() == 0 && exp_b_q.size() == 0 && exp_r_q.size() == 0;
    end
    if (!done) flag({"idle_timeout_", name});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, req_valid, 1'b0);
    check({tag, "_bvalid"}, axi_bvalid, 1'b0);
    check({tag, "_rvalid"}, axi_rvalid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_bresp"}, axi_bresp, 2'b00);
    check({tag, "_rresp"}, axi_rresp, 2'b00);
    check({tag, "_rdata"}, axi_rdata, 32'h0);
    check({tag, "_req_addr"}, req_addr, 32'h0);
    check({tag, "_req_wdata"}, req_wdata, 32'h0);
    check({tag, "_req_write"}, req_write, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  int n_ar;

  initial begin
    aresetn = 1'b0;
    axi_awaddr = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wvalid = 1'b0;
    axi_araddr = '0; axi_arvalid = 1'b0;
    axi_bready = 1'b1; axi_rready = 1'b1; req_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", axi_awready, 1'b0);
    check("rst_wready", axi_wready, 1'b0);
    check("rst_arready", axi_arready, 1'b0);
    check_reset_outputs("rst");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_awready", axi_awready, 1'b1);
    check("rel_wready", axi_wready, 1'b1);
    check("rel_arready", axi_arready, 1'b1);

    // Stray completion while idle must be ignored
    @(posedge aclk); #1; rsp_valid = 1'b1;
    @(posedge aclk); #1; rsp_valid = 1'b0;
    repeat (3) @(negedge aclk);
    check("stray_rsp_busy", busy, 1'b0);

    // Write with W one cycle ahead of AW
    exp_req_q.push_back({1'b1, 32'h100, 32'hDEADBEEF});
    exp_b_q.push_back(2'b00);
    @(posedge aclk); #1; axi_wvalid = 1'b1; axi_wdata = 32'hDEADBEEF;
    @(posedge aclk); #1; axi_wvalid = 1'b0; axi_awvalid = 1'b1; axi_awaddr = 32'h100;
    @(posedge aclk); #1; axi_awvalid = 1'b0;
    wait_idle("write_basic");

    // Read with latency checks and an rready stall
    core_rdata = 32'h12345678;
    exp_req_q.push_back({1'b0, 32'h204, 32'h0});
    exp_r_q.push_back({32'h12345678, 2'b00});
    axi_rready = 1'b0;
    @(posedge aclk); #1; axi_arvalid = 1'b1; axi_araddr = 32'h204;
    n_ar = cyc;
    @(posedge aclk); #1; axi_arvalid = 1'b0;
    wait_for(0, "read_req");
    check("read_req_latency", cyc, n_ar + 2);
    wait_for(2, "read_rvalid");
    check("read_rvalid_latency", cyc, rsp_cyc + 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("stall_rvalid", axi_rvalid, 1'b1);
      check("stall_rdata", axi_rdata, 32'h12345678);
    end
    @(posedge aclk); #1; axi_rready = 1'b1;
    wait_idle("read_basic");

    // Round robin from reset: write, read, write, read
    do_reset();
    core_rdata = 32'hCAFE0001;
    exp_req_q.push_back({1'b1, 32'h10, 32'hA5A5A5A5});
    exp_req_q.push_back({1'b0, 32'h20, 32'h0});
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back({32'hCAFE0001, 2'b00});
    send_both(32'h10, 32'hA5A5A5A5, 32'h20);
    wait_idle("rr_round1");
    exp_req_q.push_back({1'b1, 32'h30, 32'h5A5A5A5A});
    exp_req_q.push_back({1'b0, 32'h40, 32'h0});
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back({32'hCAFE0001, 2'b00});
    send_both(32'h30, 32'h5A5A5A5A, 32'h40);
    wait_idle("rr_round2");

    // Slave error from the core on write and read
    core_err = 1'b1;
    core_rdata = 32'hBAD0BAD0;
    exp_req_q.push_back({1'b1, 32'h44, 32'h11});
    exp_b_q.push_back(2'b10);
    send_write(32'h44, 32'h11);
    wait_idle("write_err");
    exp_req_q.push_back({1'b0, 32'h48, 32'h0});
    exp_r_q.push_back({32'hBAD0BAD0, 2'b10});
    send_read(32'h48);
    wait_idle("read_err");
    core_err = 1'b0;

    // Unaligned accesses bypass the core
    exp_r_q.push_back({32'h0, 2'b10});
    send_read(32'h203);
    wait_idle("unaligned_read");
    exp_b_q.push_back(2'b10);
    send_write(32'h102, 32'h77);
    wait_idle("unaligned_write");

    // Last grant was the unaligned write, so a tie now goes to the read
    core_rdata = 32'h0000BEEF;
    exp_req_q.push_back({1'b0, 32'h50, 32'h0});
    exp_req_q.push_back({1'b1, 32'h54, 32'h99});
    exp_r_q.push_back({32'h0000BEEF, 2'b00});
    exp_b_q.push_back(2'b00);
    send_both(32'h54, 32'h99, 32'h50);
    wait_idle("rr_after_unaligned");

    // Timeout: no completion ever arrives
    core_en = 1'b0;
    exp_req_q.push_back({1'b1, 32'h60, 32'h1234});
    exp_b_q.push_back(2'b10);
    send_write(32'h60, 32'h1234);
    wait_for(1, "timeout_bvalid");
    check("timeout_latency", cyc, hs_cyc + 1 + TO);
    wait_idle("timeout");
    core_en = 1'b1;

    // Completion in the last counted cycle beats the timeout
    core_dly = TO;
    exp_req_q.push_back({1'b1, 32'h64, 32'h4321});
    exp_b_q.push_back(2'b00);
    send_write(32'h64, 32'h4321);
    wait_idle("rsp_at_limit");
    core_dly = 2;

    // Reset while waiting for the core
    core_en = 1'b0;
    exp_req_q.push_back({1'b1, 32'h70, 32'h55});
    send_write(32'h70, 32'h55);
    wait_for(0, "midrst_req");
    repeat (3) @(posedge aclk);
    #1; aresetn = 1'b0;
    @(negedge aclk);
    check("midrst_awready_low", axi_awready, 1'b0);
    @(posedge aclk); #1; aresetn = 1'b1;
    @(negedge aclk);
    check_reset_outputs("midrst");
    @(posedge aclk); #1; rsp_valid = 1'b1; rsp_err = 1'b1;
    @(posedge aclk); #1; rsp_valid = 1'b0; rsp_err = 1'b0;
    repeat (20) @(negedge aclk);
    check("midrst_late_rsp_busy", busy, 1'b0);
    core_en = 1'b1;

    check("leftover_expectations", exp_req_q.size() + exp_b_q.size() + exp_r_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
